// File: rtl/uart_frame_parser.sv
// uart_frame_parser: delineates HDR0 HDR1 LEN CMD PAYLOAD[LEN] CHK frames from a
// UART byte stream, checks length and checksum, and publishes good frames
// through a double-buffered read port.
module uart_frame_parser #(
  parameter int unsigned CLK_FREQ   = 50,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned MAX_LEN    = 16,
  parameter logic [7:0]  HDR0       = 8'h55,
  parameter logic [7:0]  HDR1       = 8'hAA,
  localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_data_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    frame_cmd,
  output logic [7:0]    frame_len,
  output logic          frame_done,
  output logic          frame_err,
  output logic [1:0]    err_code,
  output logic          busy
);

  localparam int unsigned TIMEOUT_CYC = CLK_FREQ * TIMEOUT_US;
  localparam int unsigned CW          = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_LEN,
    S_CMD,
    S_DATA,
    S_CHK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          done_c;
  logic          err_c;
  logic [1:0]    code_c;
  logic          gap_hit_c;

  logic [7:0]    len;
  logic [7:0]    cmd;
  logic [7:0]    sum;
  logic [AW-1:0] idx;
  logic [CW-1:0] gap_cnt;
  logic [7:0]    work_buf [MAX_LEN];
  logic [7:0]    out_buf  [MAX_LEN];

  // Consumer view: only the published buffer is visible.
  assign rd_data = out_buf[rd_addr];

  // Inter-byte gap expires on this cycle unless a byte arrives.
  assign gap_hit_c = (state != S_HDR0) && (gap_cnt == CW'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HDR0;
    else        state <= state_nxt;
  end

  // Next-state decode plus completion/abort strobes.
  always_comb begin
    state_nxt = state;
    done_c    = 1'b0;
    err_c     = 1'b0;
    code_c    = 2'd0;
    if (rx_data_valid) begin
      unique case (state)
        S_HDR0: if (rx_data == HDR0) state_nxt = S_HDR1;
        S_HDR1: begin
          if (rx_data == HDR1)      state_nxt = S_LEN;
          else if (rx_data != HDR0) state_nxt = S_HDR0;
        end
        S_LEN: begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            state_nxt = S_HDR0;
            err_c     = 1'b1;
            code_c    = 2'd1;
          end else begin
            state_nxt = S_CMD;
          end
        end
        S_CMD:  state_nxt = S_DATA;
        S_DATA: if (8'(idx) == len - 8'd1) state_nxt = S_CHK;
        S_CHK: begin
          state_nxt = S_HDR0;
          if (rx_data == sum) begin
            done_c = 1'b1;
          end else begin
            err_c  = 1'b1;
            code_c = 2'd2;
          end
        end
        default: state_nxt = S_HDR0;
      endcase
    end else if (gap_hit_c) begin
      state_nxt = S_HDR0;
      err_c     = 1'b1;
      code_c    = 2'd3;
    end
  end

  // Datapath: frame capture, gap counter, publication and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len        <= '0;
      cmd        <= '0;
      sum        <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      frame_cmd  <= '0;
      frame_len  <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      busy       <= 1'b0;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        work_buf[i] <= '0;
        out_buf[i]  <= '0;
      end
    end else begin
      frame_done <= done_c;
      frame_err  <= err_c;
      busy       <= (state_nxt != S_HDR0);
      if (err_c) err_code <= code_c;

      if (rx_data_valid || state == S_HDR0 || gap_hit_c) gap_cnt <= '0;
      else                                                gap_cnt <= gap_cnt + CW'(1);

      if (rx_data_valid) begin
        unique case (state)
          S_LEN: begin
            len <= rx_data;
            sum <= rx_data;
            idx <= '0;
          end
          S_CMD: begin
            cmd <= rx_data;
            sum <= sum + rx_data;
          end
          S_DATA: begin
            work_buf[idx] <= rx_data;
            sum           <= sum + rx_data;
            idx           <= idx + AW'(1);
          end
          default: ;
        endcase
      end

      if (done_c) begin
        out_buf   <= work_buf;
        frame_cmd <= cmd;
        frame_len <= len;
      end
    end
  end

endmodule
